mux_4to1: RTL and testbench

MUX_4TO1 -- requirements
Module: mux_4to1

---
 rtl/mux_4to1.sv | 45 ++++
 tb/tb_mux_4to1.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_4to1.sv
// Four-lane W-bit selector with a registered, 1-clock-latency output.
// Defining MUX_4TO1_COMB_OUT_EN makes the output path combinational.
module mux_4to1 #(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [4*W-1:0] I,
    input  logic [1:0]     S,
    output logic [W-1:0]   Y,
    output logic           out_valid
);

    logic [W-1:0] lane_sel;

    // All four select codes address a real lane, so no default/X branch is needed.
    assign lane_sel = I[S*W +: W];

`ifdef MUX_4TO1_COMB_OUT_EN

    // Clock and reset are kept on the port list but unused in this build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign Y         = lane_sel;
    assign out_valid = in_valid;

`else

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Y <= lane_sel;
            end
        end
    end

`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: W=1 and W=8 instances side by side,
// directed vectors plus randomized traffic against a behavioural model.
module tb_mux_4to1;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  S;
    logic [3:0]  I1;
    logic [31:0] I8;
    logic        Y1;
    logic [7:0]  Y8;
    logic        ov1;
    logic        ov8;

    int checks = 0;
    int errors = 0;

    // model state
    logic       exp_y1;
    logic [7:0] exp_y8;
    logic       exp_ov;

    mux_4to1 #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .I(I1), .S(S), .Y(Y1), .out_valid(ov1)
    );

    mux_4to1 #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .I(I8), .S(S), .Y(Y8), .out_valid(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic lane1(input logic [3:0] data, input logic [1:0] sel);
        return logic'((data >> sel) & 4'h1);
    endfunction

    function automatic logic [7:0] lane8(input logic [31:0] data, input logic [1:0] sel);
        return 8'((data >> (8 * int'(sel))) & 32'hFF);
    endfunction

`ifdef MUX_4TO1_COMB_OUT_EN

    task automatic test_comb();
        I1 = 4'b1011; I8 = 32'hDDCCBBAA; S = 2'b10; in_valid = 1'b1; rst = 1'b1;
        #1;
        checks++;
        if (Y1 !== 1'b0) begin errors++; $display("FAIL comb_y got %b want 0", Y1); end
        checks++;
        if (ov1 !== 1'b1) begin errors++; $display("FAIL comb_ov_hi got %b want 1", ov1); end
        checks++;
        if (Y8 !== 8'hCC) begin errors++; $display("FAIL comb_y8 got %h want cc", Y8); end
        in_valid = 1'b0;
        #1;
        checks++;
        if (ov1 !== 1'b0) begin errors++; $display("FAIL comb_ov_lo got %b want 0", ov1); end
        for (int n = 0; n < 60; n++) begin
            I1 = 4'($urandom); I8 = $urandom; S = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom); rst = 1'($urandom);
            #3;
            checks++;
            if (Y1 !== lane1(I1, S)) begin errors++; $display("FAIL comb_rand_y1 got %b want %b", Y1, lane1(I1, S)); end
            checks++;
            if (Y8 !== lane8(I8, S)) begin errors++; $display("FAIL comb_rand_y8 got %h want %h", Y8, lane8(I8, S)); end
            checks++;
            if (ov8 !== in_valid) begin errors++; $display("FAIL comb_rand_ov got %b want %b", ov8, in_valid); end
        end
    endtask

`else

    // Advance one clock, update the model from the inputs seen at the edge,
    // and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            exp_y1 = 1'b0; exp_y8 = 8'h00; exp_ov = 1'b0;
        end else begin
            exp_ov = in_valid;
            if (in_valid) begin
                exp_y1 = lane1(I1, S);
                exp_y8 = lane8(I8, S);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; I1 = 4'b1111; I8 = 32'hFFFFFFFF; S = 2'b00;
        #1 rst = 1'b1;
        exp_y1 = 1'b0; exp_y8 = 8'h00; exp_ov = 1'b0;
        #2;
        checks++;
        if (Y1 !== 1'b0 || Y8 !== 8'h00) begin errors++; $display("FAIL reset_y got %b/%h want 0/00", Y1, Y8); end
        checks++;
        if (ov1 !== 1'b0 || ov8 !== 1'b0) begin errors++; $display("FAIL reset_ov got %b/%b want 0/0", ov1, ov8); end
        @(negedge clk);
        tick();
        checks++;
        if (Y1 !== 1'b0 || ov1 !== 1'b0) begin errors++; $display("FAIL reset_held got y=%b ov=%b want 0/0", Y1, ov1); end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_lane_sweep(input logic [3:0] data, input logic [3:0] want);
        logic [3:0] w;
        w = want;
        I1 = data; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            S = 2'(k); I8 = $urandom;
            tick();
            checks++;
            if (Y1 !== w[k] || Y1 !== exp_y1) begin errors++; $display("FAIL sweep_y I=%b S=%0d got %b want %b", data, k, Y1, w[k]); end
            checks++;
            if (ov1 !== 1'b1) begin errors++; $display("FAIL sweep_ov S=%0d got %b want 1", k, ov1); end
            checks++;
            if (Y8 !== exp_y8) begin errors++; $display("FAIL sweep_y8 got %h want %h", Y8, exp_y8); end
        end
    endtask

    task automatic test_hold();
        I1 = 4'b1011; S = 2'b10; in_valid = 1'b1;
        tick();
        checks++;
        if (Y1 !== 1'b0) begin errors++; $display("FAIL hold_load got %b want 0", Y1); end
        in_valid = 1'b0; I1 = 4'b0100; S = 2'b10; I8 = $urandom;
        tick();
        checks++;
        if (Y1 !== 1'b0 || ov1 !== 1'b0) begin errors++; $display("FAIL hold got y=%b ov=%b want 0/0", Y1, ov1); end
        checks++;
        if (Y8 !== exp_y8) begin errors++; $display("FAIL hold_y8 got %h want %h", Y8, exp_y8); end
        // input changes between edges must not reach the registered output
        in_valid = 1'b1; I1 = 4'b1111; I8 = ~I8; S = 2'b01;
        #3;
        checks++;
        if (Y1 !== 1'b0 || Y8 !== exp_y8) begin errors++; $display("FAIL no_edge got %b/%h want 0/%h", Y1, Y8, exp_y8); end
        tick();
        checks++;
        if (Y1 !== 1'b1 || ov1 !== 1'b1) begin errors++; $display("FAIL after_edge got y=%b ov=%b want 1/1", Y1, ov1); end
    endtask

    task automatic test_same_select();
        I1 = 4'b0010; S = 2'b01; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (ov1 !== 1'b1 || Y1 !== 1'b1) begin errors++; $display("FAIL repeat_sel #%0d got y=%b ov=%b want 1/1", k, Y1, ov1); end
        end
    endtask

    task automatic test_async_reset();
        I1 = 4'b1000; S = 2'b11; in_valid = 1'b1;
        tick();
        checks++;
        if (Y1 !== 1'b1) begin errors++; $display("FAIL pre_reset_y got %b want 1", Y1); end
        #2 rst = 1'b1;
        exp_y1 = 1'b0; exp_y8 = 8'h00; exp_ov = 1'b0;
        #1;
        checks++;
        if (Y1 !== 1'b0 || ov1 !== 1'b0 || Y8 !== 8'h00) begin errors++; $display("FAIL async_reset got y=%b ov=%b y8=%h want 0/0/00", Y1, ov1, Y8); end
        // reset held through an edge with valid input: nothing may emerge
        @(negedge clk);
        tick();
        checks++;
        if (ov1 !== 1'b0 || Y1 !== 1'b0) begin errors++; $display("FAIL reset_discard got y=%b ov=%b want 0/0", Y1, ov1); end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        I1 = 4'b1000; S = 2'b11; in_valid = 1'b1;
        tick();
        checks++;
        if (Y1 !== 1'b1 || ov1 !== 1'b1) begin errors++; $display("FAIL post_reset got y=%b ov=%b want 1/1", Y1, ov1); end
    endtask

    task automatic test_wide();
        I8 = 32'hDDCCBBAA; in_valid = 1'b1; S = 2'b10;
        tick();
        checks++;
        if (Y8 !== 8'hCC) begin errors++; $display("FAIL wide_s2 got %h want cc", Y8); end
        S = 2'b11;
        tick();
        checks++;
        if (Y8 !== 8'hDD || ov8 !== 1'b1) begin errors++; $display("FAIL wide_s3 got %h ov=%b want dd/1", Y8, ov8); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            I1 = 4'($urandom); I8 = $urandom; S = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (Y1 !== exp_y1) begin errors++; $display("FAIL rand_y1 cyc %0d got %b want %b", n, Y1, exp_y1); end
            checks++;
            if (Y8 !== exp_y8) begin errors++; $display("FAIL rand_y8 cyc %0d got %h want %h", n, Y8, exp_y8); end
            checks++;
            if (ov1 !== exp_ov || ov8 !== exp_ov) begin errors++; $display("FAIL rand_ov cyc %0d got %b/%b want %b", n, ov1, ov8, exp_ov); end
        end
    endtask

`endif

    initial begin
        rst = 1'b0; in_valid = 1'b0; S = 2'b00; I1 = '0; I8 = '0;
        exp_y1 = 1'b0; exp_y8 = 8'h00; exp_ov = 1'b0;
`ifdef MUX_4TO1_COMB_OUT_EN
        test_comb();
`else
        test_reset();
        test_lane_sweep(4'b1011, 4'b1011);
        test_lane_sweep(4'b0101, 4'b0101);
        test_hold();
        test_same_select();
        test_async_reset();
        test_wide();
        test_back_to_back();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
